// File: rtl/conv_stream_param.sv
// conv_stream_param: streaming 1-D valid convolution with saturating MAC lanes.
// Loads N samples and M coefficients. It then computes
// y[k] = sum_j x[k+j]*f[j] for k = 0..N-M, processing P consecutive k per group,
// and streams each group's results out in ascending k.
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   x_data/x_valid/x_ready - signed input sample stream
//   f_data/f_valid/f_ready - signed filter coefficient stream
//   y_data/y_valid/y_ready - signed result stream
module conv_stream_param #(
  parameter int unsigned N    = 32,
  parameter int unsigned M    = 10,
  parameter int unsigned T    = 16,
  parameter int unsigned P    = 1,
  parameter int unsigned RELU = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [T-1:0] x_data,
  input  logic                x_valid,
  output logic                x_ready,
  input  logic signed [T-1:0] f_data,
  input  logic                f_valid,
  output logic                f_ready,
  output logic signed [T-1:0] y_data,
  output logic                y_valid,
  input  logic                y_ready
);

  localparam int unsigned KLAST = N - M;
  localparam int unsigned CW    = $clog2(N + P + 1);
  localparam int unsigned XIW   = $clog2(N);
  localparam int unsigned JW    = $clog2(M);
  localparam int unsigned LW    = (P > 1) ? $clog2(P) : 1;
  localparam logic signed [T-1:0] SMAX = {1'b0, {(T-1){1'b1}}};
  localparam logic signed [T-1:0] SMIN = {1'b1, {(T-1){1'b0}}};

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_OUTPUT} state_t;

  // Clamp a full-width product to T bits
  function automatic logic signed [T-1:0] sat_p(input logic signed [2*T-1:0] v);
    if (v > (2*T)'(SMAX))      sat_p = SMAX;
    else if (v < (2*T)'(SMIN)) sat_p = SMIN;
    else                       sat_p = T'(v);
  endfunction

  // Clamp a T+1 bit sum to T bits
  function automatic logic signed [T-1:0] sat_s(input logic signed [T:0] v);
    if (v > (T+1)'(SMAX))      sat_s = SMAX;
    else if (v < (T+1)'(SMIN)) sat_s = SMIN;
    else                       sat_s = T'(v);
  endfunction

  state_t              r_state;
  state_t              w_state_n;
  logic signed [T-1:0] r_x_mem [N];
  logic signed [T-1:0] r_f_mem [M];
  logic [CW-1:0]       r_x_cnt;
  logic [CW-1:0]       r_f_cnt;
  logic [CW-1:0]       r_kb;
  logic [JW-1:0]       r_j;
  logic [LW-1:0]       r_lane;
  logic signed [T-1:0] r_acc [P];
  logic                r_x_ready;
  logic                r_f_ready;
  logic                r_y_valid;
  logic signed [T-1:0] r_y_data;

  logic                w_x_acc;
  logic                w_f_acc;
  logic [CW-1:0]       w_x_cnt_n;
  logic [CW-1:0]       w_f_cnt_n;
  logic                w_load_done;
  logic                w_last_j;
  logic [CW-1:0]       w_k;
  logic                w_last_lane;
  logic                w_y_fire;
  logic signed [T-1:0] w_x_sel  [P];
  logic signed [T-1:0] w_prod   [P];
  logic signed [T-1:0] w_base   [P];
  logic signed [T-1:0] w_sum    [P];
  logic signed [T-1:0] w_acc_n  [P];
  logic signed [T-1:0] w_y_next;

  assign x_ready = r_x_ready;
  assign f_ready = r_f_ready;
  assign y_valid = r_y_valid;
  assign y_data  = r_y_data;

  assign w_x_acc     = x_valid && r_x_ready;
  assign w_f_acc     = f_valid && r_f_ready;
  assign w_x_cnt_n   = r_x_cnt + CW'(w_x_acc);
  assign w_f_cnt_n   = r_f_cnt + CW'(w_f_acc);
  assign w_load_done = (r_state == S_LOAD) && (w_x_cnt_n == CW'(N)) && (w_f_cnt_n == CW'(M));
  assign w_last_j    = (r_j == JW'(M - 1));
  assign w_k         = r_kb + CW'(r_lane);
  // A group ends at its last lane or at y[N-M], whichever comes first
  assign w_last_lane = (w_k == CW'(KLAST)) || (r_lane == LW'(P - 1));
  assign w_y_fire    = r_y_valid && y_ready;

  // One MAC step per lane: lane l works on k = kb + l, tap j = r_j
  always_comb begin
    for (int l = 0; l < P; l++) begin
      w_x_sel[l] = '0;
      for (int i = 0; i < N; i++) begin
        if (CW'(i) == r_kb + CW'(l) + CW'(r_j)) w_x_sel[l] = r_x_mem[i];
      end
      w_prod[l] = sat_p((2*T)'(w_x_sel[l]) * (2*T)'(r_f_mem[r_j]));
      if (r_j == '0) w_base[l] = '0;
      else           w_base[l] = r_acc[l];
      w_sum[l]   = sat_s((T+1)'(w_base[l]) + (T+1)'(w_prod[l]));
      w_acc_n[l] = w_sum[l];
      // ReLU only on the completed sum; intermediate sums may be negative
      if ((RELU != 0) && w_last_j && (w_sum[l] < 0)) w_acc_n[l] = '0;
    end
  end

  // Result of the lane following the one currently presented
  always_comb begin
    w_y_next = '0;
    for (int l = 0; l < P; l++) begin
      if (LW'(l) == r_lane + LW'(1)) w_y_next = r_acc[l];
    end
  end

  // Next-state logic
  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      S_LOAD:    if (w_load_done) w_state_n = S_COMPUTE;
      S_COMPUTE: if (w_last_j) w_state_n = S_OUTPUT;
      S_OUTPUT:  if (w_y_fire && w_last_lane)
                   w_state_n = (w_k == CW'(KLAST)) ? S_LOAD : S_COMPUTE;
      default:   w_state_n = S_LOAD;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_LOAD;
    else       r_state <= w_state_n;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x_cnt   <= '0;
      r_f_cnt   <= '0;
      r_kb      <= '0;
      r_j       <= '0;
      r_lane    <= '0;
      r_x_ready <= 1'b0;
      r_f_ready <= 1'b0;
      r_y_valid <= 1'b0;
      r_y_data  <= '0;
      for (int l = 0; l < P; l++) r_acc[l] <= '0;
    end else begin
      unique case (r_state)
        S_LOAD: begin
          if (w_x_acc) r_x_mem[XIW'(r_x_cnt)] <= x_data;
          if (w_f_acc) r_f_mem[JW'(r_f_cnt)]  <= f_data;
          if (w_load_done) begin
            r_x_cnt   <= '0;
            r_f_cnt   <= '0;
            r_x_ready <= 1'b0;
            r_f_ready <= 1'b0;
            r_kb      <= '0;
            r_j       <= '0;
          end else begin
            // Ready rises one cycle into LOAD and drops after the last word
            r_x_cnt   <= w_x_cnt_n;
            r_f_cnt   <= w_f_cnt_n;
            r_x_ready <= (w_x_cnt_n != CW'(N));
            r_f_ready <= (w_f_cnt_n != CW'(M));
          end
        end
        S_COMPUTE: begin
          for (int l = 0; l < P; l++) r_acc[l] <= w_acc_n[l];
          if (w_last_j) begin
            r_j       <= '0;
            r_lane    <= '0;
            r_y_valid <= 1'b1;
            r_y_data  <= w_acc_n[0];
          end else begin
            r_j <= r_j + JW'(1);
          end
        end
        S_OUTPUT: begin
          if (w_y_fire) begin
            if (w_last_lane) begin
              r_y_valid <= 1'b0;
              r_kb      <= r_kb + CW'(P);
            end else begin
              r_lane   <= r_lane + LW'(1);
              r_y_data <= w_y_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_stream_param.sv
// tb_conv_stream_param: scoreboard bench for conv_stream_param.
// Three instances share one input stream: defaults, RELU=0, and P=4.
// Expected results are pushed per instance when a vector is issued. A monitor
// pops and compares every accepted output and checks that stalled data stays stable.
module tb_conv_stream_param;

  localparam int NN = 32;
  localparam int MM = 10;
  localparam int NOUT = NN - MM + 1;

  logic clk;
  logic reset;
  logic signed [15:0] x_dat;
  logic signed [15:0] f_dat;
  logic x_vld;
  logic f_vld;
  logic [2:0] x_rdy;
  logic [2:0] f_rdy;
  logic [2:0] y_vld;
  logic [2:0] y_rdy;
  logic signed [15:0] y_dat [3];

  int checks;
  int failures;
  int rand_y;
  int q0[$];
  int q1[$];
  int q2[$];
  logic [2:0] stalled;
  logic signed [15:0] held [3];

  conv_stream_param dut0 (
    .clk(clk), .reset(reset),
    .x_data(x_dat), .x_valid(x_vld), .x_ready(x_rdy[0]),
    .f_data(f_dat), .f_valid(f_vld), .f_ready(f_rdy[0]),
    .y_data(y_dat[0]), .y_valid(y_vld[0]), .y_ready(y_rdy[0])
  );

  conv_stream_param #(.RELU(0)) dut1 (
    .clk(clk), .reset(reset),
    .x_data(x_dat), .x_valid(x_vld), .x_ready(x_rdy[1]),
    .f_data(f_dat), .f_valid(f_vld), .f_ready(f_rdy[1]),
    .y_data(y_dat[1]), .y_valid(y_vld[1]), .y_ready(y_rdy[1])
  );

  conv_stream_param #(.P(4)) dut2 (
    .clk(clk), .reset(reset),
    .x_data(x_dat), .x_valid(x_vld), .x_ready(x_rdy[2]),
    .f_data(f_dat), .f_valid(f_vld), .f_ready(f_rdy[2]),
    .y_data(y_dat[2]), .y_valid(y_vld[2]), .y_ready(y_rdy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic signed [15:0] xval(input int mode, input int i);
    case (mode)
      0: return 16'sd1;
      1: return 16'sd32767;
      2: return -16'sd100;
      3: return 16'(i);
      default: return 16'sd2;
    endcase
  endfunction

  function automatic logic signed [15:0] fval(input int mode);
    case (mode)
      0: return 16'sd1;
      1: return 16'sd32767;
      2: return 16'sd100;
      3: return 16'sd1;
      default: return 16'sd3;
    endcase
  endfunction

  // Hand-derived results for each stimulus pattern
  function automatic int expv(input int mode, input int k, input int inst);
    case (mode)
      0: return 10;
      1: return 32767;
      2: return (inst == 1) ? -32768 : 0;
      3: return 10 * k + 45;
      default: return 60;
    endcase
  endfunction

  // Output back-pressure: always ready, or 50% random
  initial begin
    y_rdy = 3'b111;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) y_rdy[i] = (rand_y != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Scoreboard monitor
  initial begin
    stalled = '0;
    forever begin
      @(negedge clk);
      #2;
      for (int i = 0; i < 3; i++) begin
        if (stalled[i]) begin
          chk($sformatf("stall_valid%0d", i), int'(y_vld[i]), 1);
          chk($sformatf("stall_data%0d", i), int'(y_dat[i]), int'(held[i]));
        end
        if (y_vld[i] && y_rdy[i]) begin
          int e;
          int have;
          have = 1;
          e = 0;
          case (i)
            0: if (q0.size() > 0) e = q0.pop_front(); else have = 0;
            1: if (q1.size() > 0) e = q1.pop_front(); else have = 0;
            default: if (q2.size() > 0) e = q2.pop_front(); else have = 0;
          endcase
          if (have == 0) chk($sformatf("unexpected_out%0d", i), int'(y_dat[i]), 99999);
          else           chk($sformatf("y_data%0d", i), int'(y_dat[i]), e);
        end
        stalled[i] = y_vld[i] && !y_rdy[i];
        held[i]    = y_dat[i];
      end
    end
  end

  // Feed nx samples and nf coefficients; a word is offered only when every instance is ready
  task automatic drive(input int nx, input int nf, input int mode);
    int xi;
    int fi;
    int guard;
    xi = 0;
    fi = 0;
    guard = 0;
    x_vld = 1'b0;
    f_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (x_vld) xi++;
      if (f_vld) fi++;
      x_vld = 1'b0;
      f_vld = 1'b0;
      if (xi >= nx && fi >= nf) break;
      guard++;
      if (guard > 3000) begin
        chk("load_timeout", xi * 100 + fi, nx * 100 + nf);
        break;
      end
      if (xi < nx && (&x_rdy)) begin
        x_dat = xval(mode, xi);
        x_vld = 1'b1;
      end
      if (fi < nf && (&f_rdy)) begin
        f_dat = fval(mode);
        f_vld = 1'b1;
      end
    end
  endtask

  task automatic run_vec(input int mode, input int rnd);
    int t;
    for (int k = 0; k < NOUT; k++) begin
      q0.push_back(expv(mode, k, 0));
      q1.push_back(expv(mode, k, 1));
      q2.push_back(expv(mode, k, 2));
    end
    rand_y = rnd;
    drive(NN, MM, mode);
    t = 0;
    while ((q0.size() + q1.size() + q2.size()) > 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) chk("drain_timeout", q0.size() + q1.size() + q2.size(), 0);
    rand_y = 0;
    repeat (4) @(negedge clk);
    // All instances back in LOAD and accepting again
    chk($sformatf("reload_ready_m%0d", mode), int'({x_rdy, f_rdy}), 63);
    chk($sformatf("idle_valid_m%0d", mode), int'(y_vld), 0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rand_y = 0;
    reset = 1'b1;
    x_vld = 1'b0;
    f_vld = 1'b0;
    x_dat = '0;
    f_dat = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_x_ready%0d", i), int'(x_rdy[i]), 0);
      chk($sformatf("rst_f_ready%0d", i), int'(f_rdy[i]), 0);
      chk($sformatf("rst_y_valid%0d", i), int'(y_vld[i]), 0);
      chk($sformatf("rst_y_data%0d", i), int'(y_dat[i]), 0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", int'({x_rdy, f_rdy}), 63);

    run_vec(0, 0);
    run_vec(1, 0);
    run_vec(2, 0);
    run_vec(3, 1);

    // Abort a partial load with reset, then reload completely
    drive(5, 3, 4);
    reset = 1'b1;
    @(negedge clk);
    chk("midload_rst_ready", int'({x_rdy, f_rdy}), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("midload_post_ready", int'({x_rdy, f_rdy}), 63);
    run_vec(4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_stream_param.md
CONV_STREAM_PARAM -- requirements
Module: conv_stream_param

Interface
REQ-001 SHALL have parameter N, default 32: input vector length.
REQ-002 SHALL have parameter M, default 10: filter length, 2 <= M <= N.
REQ-003 SHALL have parameter T, default 16: signed data/result width.
REQ-004 SHALL have parameter P, default 1: parallel MAC lanes, 1 <= P <= N-M+1.
REQ-005 SHALL have parameter RELU, default 1: 1 clamps negative results to 0; 0 passes them through.
REQ-006 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port x_data, input, T bits: signed input sample.
REQ-009 SHALL have ports x_valid (input, 1 bit) and x_ready (output, 1 bit): input-sample handshake.
REQ-010 SHALL have port f_data, input, T bits: signed filter coefficient.
REQ-011 SHALL have ports f_valid (input, 1 bit) and f_ready (output, 1 bit): coefficient handshake.
REQ-012 SHALL have port y_data, output, T bits: signed result.
REQ-013 SHALL have ports y_valid (output, 1 bit) and y_ready (input, 1 bit): result handshake.

Function
REQ-014 SHALL run the state machine LOAD -> COMPUTE -> OUTPUT -> (COMPUTE | LOAD).
REQ-015 SHALL transfer a word only on a cycle where valid && ready are both 1.
REQ-016 SHALL, in LOAD, hold x_ready=1 until N samples are accepted and f_ready=1 until M coefficients are accepted.
- The x and f streams are independent and may interleave or occur in the same cycle.
- Each ready drops on the cycle after its last accepted word.
REQ-017 SHALL enter COMPUTE on the cycle after both the N-th x and the M-th f are accepted.
REQ-018 SHALL hold x_ready=0 and f_ready=0 in COMPUTE and OUTPUT, and ignore x_valid and f_valid there.
REQ-019 SHALL compute y[k] = sum over j=0..M-1 of x[k+j]*f[j], for k = 0..N-M, in groups of P consecutive k.
- Number of groups is ceil((N-M+1)/P).
REQ-020 SHALL saturate each product to T bits: the max is 2^(T-1)-1 and the min is -2^(T-1).
REQ-021 SHALL saturate each accumulation step to T bits with the same limits.
- Later terms may move a saturated sum back into range.
REQ-022 SHALL apply ReLU after the full sum when RELU=1.
REQ-023 SHALL assert y_valid for the first result of a group no later than M+5 cycles after COMPUTE entry.
REQ-024 SHALL, in OUTPUT, present the group's results in ascending k, one per y_valid/y_ready transfer.
REQ-025 SHALL keep y_data stable and y_valid high while y_valid=1 && y_ready=0.
REQ-026 SHALL never present lanes with k > N-M in a partial last group.
REQ-027 SHALL, after the last lane of a group is accepted, enter COMPUTE for the next group, or enter LOAD after y[N-M].
- x_ready and f_ready rise on the cycle after entering LOAD.
REQ-028 SHALL require a full reload of both x and f for every new vector; no coefficient reuse.
REQ-029 SHALL keep y_valid=0 outside OUTPUT.

Reset
REQ-030 SHALL, on reset=1 at a clock edge, enter LOAD and discard all partial data, counts and accumulators.
- Reset takes effect regardless of state, including mid-transfer.
REQ-031 SHALL drive y_valid=0, x_ready=0, f_ready=0 and y_data=0 while reset=1.
REQ-032 SHALL drive x_ready=1 and f_ready=1 on the first cycle after reset deasserts.

Verification
REQ-033 SHALL pass: defaults, all x=1, all f=1, y_ready=1 -> 23 outputs, each 10, then return to LOAD.
REQ-034 SHALL pass: x=32767, f=32767 -> every y=32767.
REQ-035 SHALL pass: x=-100, f=100 -> y=0 with RELU=1; y=-32768 (saturated) with RELU=0.
REQ-036 SHALL pass: x[i]=i, f=1, y_ready random 50% -> y[k]=10k+45 for k=0..22, no loss or duplication, y_data stable while stalled.
REQ-037 SHALL pass: reset after 5 x and 3 f accepted, then a full reload with x=2, f=3 -> all 23 y=60.
REQ-038 SHALL pass: P=4, x[i]=i, f=1 -> 6 groups, the last holding 3 results; outputs identical to the P=1 case.
